// File: rtl/rapcla_error_monitor.sv
// Error-metric monitor for the RAPCLA adder: compares the approximate SUM/COUT
// against the exact sum and reports error count, max and total error distance per window.
module rapcla_error_monitor #(
   parameter int SIZE      = 16,
   parameter int groupsize = 8,
   parameter int NSAMP     = 16,
   parameter int CNT_W     = 16,
   parameter int ACC_W     = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [SIZE:1]             A,
   input  logic [SIZE:1]             B,
   input  logic                      CIN,
   input  logic [SIZE:1]             SUM,
   input  logic                      COUT,
   input  logic [SIZE/groupsize:1]   ApproxRCON,
   output logic                      REPORT_VALID,
   output logic [CNT_W-1:0]          ERR_COUNT,
   output logic [SIZE:0]             MAX_ED,
   output logic [ACC_W-1:0]          SUM_ED,
   output logic [SIZE/groupsize:1]   WIN_RCON,
   output logic                      ABORT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

   state_t                    r_state;
   state_t                    w_next;

   logic                      w_accept;
   logic                      w_mismatch;
   logic                      w_take;
   logic                      w_last;
   logic                      w_empty;
   logic                      w_clear;
   logic [SIZE:0]             w_ed;
   logic [ACC_W:0]            w_sum_ext;

   logic [CNT_W-1:0]          r_cnt;
   logic [SIZE/groupsize:1]   r_rcon;
   logic                      r_s1_v;
   logic [SIZE:0]             r_exact;
   logic [SIZE:0]             r_approx;
   logic                      r_s2_v;
   logic [SIZE:0]             r_ed;
   logic [CNT_W-1:0]          r_acc_err;
   logic [SIZE:0]             r_acc_max;
   logic [ACC_W-1:0]          r_acc_sum;
   logic                      r_report_valid;
   logic                      r_abort;
   logic [CNT_W-1:0]          r_err_count;
   logic [SIZE:0]             r_max_ed;
   logic [ACC_W-1:0]          r_sum_ed;
   logic [SIZE/groupsize:1]   r_win_rcon;

   // A sample whose setting differs from the window setting is consumed but dropped.
   assign w_accept   = (r_state == S_RUN) && IN_VALID;
   assign w_mismatch = w_accept && (r_cnt != '0) && (ApproxRCON != r_rcon);
   assign w_take     = w_accept && !w_mismatch;
   assign w_last     = w_take && (r_cnt == CNT_W'(NSAMP - 1));
   assign w_empty    = !r_s1_v && !r_s2_v;
   assign w_clear    = ((r_state == S_IDLE) && START) || w_mismatch;

   always_comb begin
      w_next   = r_state;
      IN_READY = 1'b0;
      case (r_state)
         S_IDLE:   if (START) w_next = S_RUN;
         S_RUN: begin
            IN_READY = 1'b1;
            if (w_mismatch)  w_next = S_IDLE;
            else if (w_last) w_next = S_DRAIN;
         end
         S_DRAIN:  if (w_empty) w_next = S_REPORT;
         S_REPORT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_ed      = (r_exact >= r_approx) ? (r_exact - r_approx) : (r_approx - r_exact);
      w_sum_ext = {1'b0, r_acc_sum} + (ACC_W + 1)'(r_ed);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt          <= '0;
         r_rcon         <= '0;
         r_s1_v         <= 1'b0;
         r_exact        <= '0;
         r_approx       <= '0;
         r_s2_v         <= 1'b0;
         r_ed           <= '0;
         r_acc_err      <= '0;
         r_acc_max      <= '0;
         r_acc_sum      <= '0;
         r_report_valid <= 1'b0;
         r_abort        <= 1'b0;
         r_err_count    <= '0;
         r_max_ed       <= '0;
         r_sum_ed       <= '0;
         r_win_rcon     <= '0;
      end else begin
         r_abort        <= w_mismatch;
         r_report_valid <= (r_state == S_DRAIN) && w_empty;

         if ((r_state == S_IDLE) && START) r_cnt <= '0;
         else if (w_take)                  r_cnt <= r_cnt + CNT_W'(1);

         if (w_take && (r_cnt == '0)) r_rcon <= ApproxRCON;

         r_s1_v <= w_take;
         if (w_take) begin
            r_exact  <= {1'b0, A} + {1'b0, B} + (SIZE + 1)'(CIN);
            r_approx <= {COUT, SUM};
         end

         r_s2_v <= r_s1_v && !w_mismatch;
         if (r_s1_v) r_ed <= w_ed;

         if (w_clear) begin
            r_acc_err <= '0;
            r_acc_max <= '0;
            r_acc_sum <= '0;
         end else if (r_s2_v) begin
            if ((r_ed != '0) && (r_acc_err != '1)) r_acc_err <= r_acc_err + CNT_W'(1);
            if (r_ed > r_acc_max) r_acc_max <= r_ed;
            // Total error distance sticks at all-ones once it overflows.
            if (w_sum_ext[ACC_W]) r_acc_sum <= '1;
            else                  r_acc_sum <= w_sum_ext[ACC_W-1:0];
         end

         if ((r_state == S_DRAIN) && w_empty) begin
            r_err_count <= r_acc_err;
            r_max_ed    <= r_acc_max;
            r_sum_ed    <= r_acc_sum;
            r_win_rcon  <= r_rcon;
         end
      end
   end

   assign REPORT_VALID = r_report_valid;
   assign ABORT        = r_abort;
   assign ERR_COUNT    = r_err_count;
   assign MAX_ED       = r_max_ed;
   assign SUM_ED       = r_sum_ed;
   assign WIN_RCON     = r_win_rcon;

endmodule

// File: tb/tb_rapcla_error_monitor.sv
// Directed bench for rapcla_error_monitor: a model computes the expected report per
// window and queues it; the report is popped and compared when REPORT_VALID arrives.
module tb_rapcla_error_monitor;
   localparam int SIZE  = 16;
   localparam int GS    = 8;
   localparam int NSAMP = 16;
   localparam int CNT_W = 16;
   localparam int ACC_W = 32;

   logic              CLK = 1'b0;
   logic              RST, START, IN_VALID, IN_READY, CIN, COUT;
   logic [SIZE:1]     A, B, SUM;
   logic [SIZE/GS:1]  ApproxRCON;
   logic              REPORT_VALID, ABORT;
   logic [CNT_W-1:0]  ERR_COUNT;
   logic [SIZE:0]     MAX_ED;
   logic [ACC_W-1:0]  SUM_ED;
   logic [SIZE/GS:1]  WIN_RCON;

   always #5 CLK = ~CLK;

   rapcla_error_monitor #(
      .SIZE(SIZE), .groupsize(GS), .NSAMP(NSAMP), .CNT_W(CNT_W), .ACC_W(ACC_W)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .CIN(CIN), .SUM(SUM), .COUT(COUT), .ApproxRCON(ApproxRCON),
      .REPORT_VALID(REPORT_VALID), .ERR_COUNT(ERR_COUNT), .MAX_ED(MAX_ED),
      .SUM_ED(SUM_ED), .WIN_RCON(WIN_RCON), .ABORT(ABORT)
   );

   typedef struct packed {
      logic [CNT_W-1:0] err;
      logic [SIZE:0]    mx;
      logic [ACC_W-1:0] sm;
      logic [SIZE/GS:1] rc;
   } rep_t;

   rep_t    sb[$];
   rep_t    last_rep;
   int      checks = 0;
   int      errors = 0;
   int      ticks  = 0;
   int      t0     = 0;
   longint  m_err, m_max, m_sum;
   logic [SIZE/GS:1] m_rc;
   int      m_n;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      ticks++;
   endtask

   task automatic start_win();
      START = 1'b1;
      tick();
      START = 1'b0;
      t0    = ticks;
      m_err = 0; m_max = 0; m_sum = 0; m_n = 0; m_rc = '0;
      chk("in_ready_run", 64'(IN_READY), 64'd1);
   endtask

   task automatic send(input logic [SIZE:1] a, input logic [SIZE:1] b, input logic cin,
                       input logic [SIZE:1] s, input logic co, input logic [SIZE/GS:1] rc);
      logic [SIZE:0] ex, ap;
      longint ed;
      A = a; B = b; CIN = cin; SUM = s; COUT = co; ApproxRCON = rc;
      IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      ex = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
      ap = {co, s};
      ed = (ex >= ap) ? longint'(ex - ap) : longint'(ap - ex);
      if (ed != 0) m_err++;
      if (ed > m_max) m_max = ed;
      m_sum += ed;
      if (m_n == 0) m_rc = rc;
      m_n++;
   endtask

   task automatic gap();
      IN_VALID = 1'b0;
      tick();
   endtask

   task automatic expect_report(input string tag, input int exp_from_start);
      rep_t r;
      int n;
      r.err = CNT_W'(m_err);
      r.mx  = (SIZE + 1)'(m_max);
      r.sm  = ACC_W'(m_sum);
      r.rc  = m_rc;
      sb.push_back(r);
      n = 0;
      while (REPORT_VALID !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      // Cycle index: cycle 1 is the cycle right after the reference edge.
      chk({tag, "_lat_last_sample"}, 64'(n + 1), 64'd4);
      chk({tag, "_lat_start"}, 64'(ticks - t0 + 1), 64'(exp_from_start));
      r = sb.pop_front();
      chk({tag, "_err_count"}, 64'(ERR_COUNT), 64'(r.err));
      chk({tag, "_max_ed"},    64'(MAX_ED),    64'(r.mx));
      chk({tag, "_sum_ed"},    64'(SUM_ED),    64'(r.sm));
      chk({tag, "_win_rcon"},  64'(WIN_RCON),  64'(r.rc));
      last_rep = r;
      tick();
      chk({tag, "_report_one_cycle"}, 64'(REPORT_VALID), 64'd0);
   endtask

   initial begin
      logic seen;
      RST = 1'b1; START = 1'b0; IN_VALID = 1'b0;
      A = '0; B = '0; CIN = 1'b0; SUM = '0; COUT = 1'b0; ApproxRCON = '0;
      tick();
      tick();
      chk("rst_in_ready",     64'(IN_READY),     64'd0);
      chk("rst_report_valid", 64'(REPORT_VALID), 64'd0);
      chk("rst_abort",        64'(ABORT),        64'd0);
      chk("rst_outputs",      64'({ERR_COUNT, MAX_ED, WIN_RCON}), 64'd0);
      chk("rst_sum_ed",       64'(SUM_ED),       64'd0);
      RST = 1'b0;
      tick();

      // Case 1: exact results, no error.
      start_win();
      for (int i = 0; i < NSAMP; i++) send(16'h01E8, 16'h011F, 1'b1, 16'h0308, 1'b0, 2'b00);
      expect_report("c1", NSAMP + 4);

      // Case 2: every sample off by 8.
      start_win();
      for (int i = 0; i < NSAMP; i++) send(16'h01E8, 16'h011F, 1'b1, 16'h0300, 1'b0, 2'b11);
      expect_report("c2", NSAMP + 4);

      // Case 4: IN_VALID gaps, same data as case 1.
      start_win();
      for (int i = 0; i < NSAMP; i++) begin
         send(16'h01E8, 16'h011F, 1'b1, 16'h0308, 1'b0, 2'b00);
         if (i != NSAMP - 1) gap();
      end
      expect_report("c4", 2 * NSAMP - 1 + 4);

      // Case 3: half the samples lose the carry-out.
      start_win();
      for (int i = 0; i < NSAMP; i++)
         send(16'hF1E0, 16'hF000, 1'b1, 16'hE1E1, (i % 2 == 0), 2'b01);
      expect_report("c3", NSAMP + 4);

      // Case 5: setting changes on sample 6.
      start_win();
      for (int i = 0; i < 5; i++) send(16'h01E8, 16'h011F, 1'b1, 16'h0300, 1'b0, 2'b00);
      ApproxRCON = 2'b01;
      IN_VALID   = 1'b1;
      tick();
      IN_VALID   = 1'b0;
      chk("c5_abort_pulse",   64'(ABORT),        64'd1);
      chk("c5_in_ready_idle", 64'(IN_READY),     64'd0);
      chk("c5_no_report",     64'(REPORT_VALID), 64'd0);
      chk("c5_keep_err",      64'(ERR_COUNT),    64'(last_rep.err));
      chk("c5_keep_max",      64'(MAX_ED),       64'(last_rep.mx));
      chk("c5_keep_sum",      64'(SUM_ED),       64'(last_rep.sm));
      chk("c5_keep_rcon",     64'(WIN_RCON),     64'(last_rep.rc));
      tick();
      chk("c5_abort_one_cycle", 64'(ABORT), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (REPORT_VALID === 1'b1 || IN_READY === 1'b1) seen = 1'b1;
         tick();
      end
      chk("c5_stays_idle", 64'(seen), 64'd0);

      // Case 6: reset while draining.
      start_win();
      for (int i = 0; i < NSAMP; i++) send(16'h01E8, 16'h011F, 1'b1, 16'h0300, 1'b0, 2'b11);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("c6_rst_flags",   64'({IN_READY, REPORT_VALID, ABORT}), 64'd0);
      chk("c6_rst_outputs", 64'({ERR_COUNT, MAX_ED, WIN_RCON}),   64'd0);
      chk("c6_rst_sum_ed",  64'(SUM_ED),                          64'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (REPORT_VALID === 1'b1 || ABORT === 1'b1) seen = 1'b1;
      end
      chk("c6_no_report_after_rst", 64'(seen), 64'd0);
      start_win();
      for (int i = 0; i < NSAMP; i++) send(16'h01E8, 16'h011F, 1'b1, 16'h0308, 1'b0, 2'b00);
      expect_report("c6_after", NSAMP + 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
